ad7606_emulator: RTL and testbench

AD7606_EMULATOR -- requirements
Module: ad7606_emulator

---
 rtl/ad7606_emulator.sv | 181 ++++++++++++++++++
 tb/tb_ad7606_emulator.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad7606_emulator.sv
// Behavioural AD7606 stand-in for controller bring-up: CONVST/BUSY timing,
// parallel-mode RD# frame readout, RESET and STBY# handling.
module ad7606_emulator #(
  parameter int unsigned BUSY_CYCLES = 200,
  parameter int unsigned RD_SETTLE   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hw_convst,
  input  logic        hw_cs,
  input  logic        hw_rd,
  input  logic        hw_reset,
  input  logic        hw_range,
  input  logic [2:0]  hw_os,
  input  logic        hw_mode_select,
  input  logic        hw_stby_n,
  output logic        hw_busy,
  output logic        hw_first_data,
  output logic [15:0] hw_data,
  output logic        hw_data_oe,
  output logic [11:0] frame_count
);

  typedef enum logic [1:0] {IDLE, CONVERT, RESET_HOLD, STANDBY} state_t;

  localparam int unsigned N_SYNC   = 7;
  localparam int unsigned S_CONVST = 0;
  localparam int unsigned S_CS     = 1;
  localparam int unsigned S_RD     = 2;
  localparam int unsigned S_RESET  = 3;
  localparam int unsigned S_RANGE  = 4;
  localparam int unsigned S_MODE   = 5;
  localparam int unsigned S_STBY   = 6;
  // CS# and RD# idle high, so their synchronizers reset to 1
  localparam logic [N_SYNC-1:0] SYNC_INIT = 7'b000_0110;

  localparam logic [11:0] CONV_LOAD   = 12'(BUSY_CYCLES - 1);
  localparam logic [2:0]  SETTLE_LOAD = 3'((RD_SETTLE > 0) ? RD_SETTLE - 1 : 0);

  state_t            state;
  logic [N_SYNC-1:0] pins;
  logic [N_SYNC-1:0] sync_meta;
  logic [N_SYNC-1:0] sync_q;
  logic              convst_d;
  logic              rd_d;
  logic [11:0]       conv_cnt;
  logic [2:0]        settle_cnt;
  logic              rd_pending;
  logic [2:0]        ptr;
  logic [15:0]       frame [8];

  logic        convst_rise;
  logic        rd_fall;
  logic        rd_rise;
  logic        cs_s;
  logic        reset_s;
  logic        range_s;
  logic        mode_s;
  logic        stby_s;
  logic        read_ok;
  logic        drive_now;
  logic [11:0] fc_next;
  logic        unused_os;

  assign unused_os = ^hw_os;

  assign pins = {hw_stby_n, hw_mode_select, hw_range, hw_reset, hw_rd, hw_cs, hw_convst};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= SYNC_INIT;
      sync_q    <= SYNC_INIT;
      convst_d  <= 1'b0;
      rd_d      <= 1'b1;
    end else begin
      sync_meta <= pins;
      sync_q    <= sync_meta;
      convst_d  <= sync_q[S_CONVST];
      rd_d      <= sync_q[S_RD];
    end
  end

  assign convst_rise = sync_q[S_CONVST] & ~convst_d;
  assign rd_fall     = ~sync_q[S_RD] & rd_d;
  assign rd_rise     = sync_q[S_RD] & ~rd_d;
  assign cs_s        = sync_q[S_CS];
  assign reset_s     = sync_q[S_RESET];
  assign range_s     = sync_q[S_RANGE];
  assign mode_s      = sync_q[S_MODE];
  assign stby_s      = sync_q[S_STBY];
  assign fc_next     = frame_count + 12'd1;

  assign read_ok = ~cs_s & ~mode_s & ~reset_s & (state != RESET_HOLD);

  always_comb begin
    drive_now = 1'b0;
    if (rd_fall)
      drive_now = (RD_SETTLE == 0);
    else if (rd_pending && settle_cnt == 3'd0)
      drive_now = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      conv_cnt      <= '0;
      settle_cnt    <= '0;
      rd_pending    <= 1'b0;
      ptr           <= '0;
      frame_count   <= '0;
      hw_busy       <= 1'b0;
      hw_first_data <= 1'b0;
      hw_data       <= '0;
      hw_data_oe    <= 1'b0;
      for (int unsigned k = 0; k < 8; k++)
        frame[k] <= '0;
    end else begin
      // Read path first: the end-of-conversion pointer clear below must win
      if (!read_ok) begin
        hw_data_oe    <= 1'b0;
        hw_data       <= '0;
        hw_first_data <= 1'b0;
        rd_pending    <= 1'b0;
      end else begin
        if (rd_fall && RD_SETTLE != 0) begin
          rd_pending <= 1'b1;
          settle_cnt <= SETTLE_LOAD;
        end else if (rd_pending) begin
          if (settle_cnt == 3'd0)
            rd_pending <= 1'b0;
          else
            settle_cnt <= settle_cnt - 3'd1;
        end
        if (drive_now) begin
          hw_data       <= frame[ptr];
          hw_data_oe    <= 1'b1;
          hw_first_data <= (ptr == 3'd0);
        end
        if (rd_rise)
          ptr <= ptr + 3'd1;
      end

      if (reset_s) begin
        state       <= RESET_HOLD;
        hw_busy     <= 1'b0;
        ptr         <= '0;
        frame_count <= '0;
        for (int unsigned k = 0; k < 8; k++)
          frame[k] <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!stby_s) begin
              state <= STANDBY;
            end else if (convst_rise) begin
              state    <= CONVERT;
              hw_busy  <= 1'b1;
              conv_cnt <= CONV_LOAD;
            end
          end
          CONVERT: begin
            if (conv_cnt == 12'd0) begin
              hw_busy     <= 1'b0;
              frame_count <= fc_next;
              ptr         <= '0;
              for (int unsigned k = 0; k < 8; k++)
                frame[k] <= {fc_next, range_s, 3'(k)};
              state <= stby_s ? IDLE : STANDBY;
            end else begin
              conv_cnt <= conv_cnt - 12'd1;
            end
          end
          RESET_HOLD: state <= IDLE;
          STANDBY:    if (stby_s) state <= IDLE;
          default:    state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ad7606_emulator.sv
// Directed + randomized bench for ad7606_emulator against a frame-level model
// (frame counter, latched range, read pointer).
module tb_ad7606_emulator;

  localparam int unsigned BC = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hw_convst = 1'b0;
  logic        hw_cs = 1'b1;
  logic        hw_rd = 1'b1;
  logic        hw_reset = 1'b0;
  logic        hw_range = 1'b0;
  logic [2:0]  hw_os = 3'd0;
  logic        hw_mode_select = 1'b0;
  logic        hw_stby_n = 1'b1;
  logic        hw_busy;
  logic        hw_first_data;
  logic [15:0] hw_data;
  logic        hw_data_oe;
  logic [11:0] frame_count;

  ad7606_emulator #(.BUSY_CYCLES(BC), .RD_SETTLE(0)) dut (
    .clk(clk), .rst(rst), .hw_convst(hw_convst), .hw_cs(hw_cs), .hw_rd(hw_rd),
    .hw_reset(hw_reset), .hw_range(hw_range), .hw_os(hw_os),
    .hw_mode_select(hw_mode_select), .hw_stby_n(hw_stby_n), .hw_busy(hw_busy),
    .hw_first_data(hw_first_data), .hw_data(hw_data), .hw_data_oe(hw_data_oe),
    .frame_count(frame_count)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: frame-level view of the emulator
  int unsigned m_fc = 0;
  int unsigned m_ptr = 0;
  logic [11:0] m_lat_fc = '0;
  logic        m_lat_rng = 1'b0;
  bit          m_valid = 1'b0;

  // BUSY pulse monitor
  int   busy_pulses = 0;
  int   run_len = 0;
  int   last_len = 0;
  logic busy_q = 1'b0;

  always @(negedge clk) begin
    if (hw_busy === 1'b1) begin
      if (busy_q !== 1'b1) begin
        busy_pulses++;
        run_len = 0;
      end
      run_len++;
    end else if (busy_q === 1'b1) begin
      last_len = run_len;
    end
    busy_q = hw_busy;
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_sample(input int unsigned p);
    logic [2:0] ch;
    ch = 3'(p);
    return m_valid ? {m_lat_fc, m_lat_rng, ch} : 16'h0000;
  endfunction

  task automatic m_convert_done(input logic rng);
    m_fc      = (m_fc + 1) % 4096;
    m_lat_fc  = 12'(m_fc);
    m_lat_rng = rng;
    m_valid   = 1'b1;
    m_ptr     = 0;
  endtask

  task automatic m_hw_reset();
    m_fc      = 0;
    m_lat_fc  = '0;
    m_lat_rng = 1'b0;
    m_valid   = 1'b0;
    m_ptr     = 0;
  endtask

  task automatic do_read(input int unsigned low, input int unsigned high,
                         input string tag, input bit expect_ok);
    hw_rd = 1'b0;
    tick(low);
    if (expect_ok) begin
      check({tag, "_data"}, 32'(hw_data), 32'(exp_sample(m_ptr)));
      check({tag, "_first"}, 32'(hw_first_data), 32'(m_ptr == 0));
      check({tag, "_oe"}, 32'(hw_data_oe), 32'd1);
    end else begin
      check({tag, "_oe_blocked"}, 32'(hw_data_oe), 32'd0);
    end
    hw_rd = 1'b1;
    tick(high);
    if (expect_ok) m_ptr = (m_ptr + 1) % 8;
  endtask

  task automatic start_conv(input string tag);
    hw_convst = 1'b1;
    tick(3);
    check({tag, "_busy_rise"}, 32'(hw_busy), 32'd1);
    tick(1);
    hw_convst = 1'b0;
  endtask

  task automatic wait_busy_low(input int unsigned bound, input string tag);
    bit ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < bound; i++) begin
      if (hw_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check({tag, "_busy_fall_in_time"}, 32'(ok), 32'd1);
    tick(1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic r;
    int unsigned n;

    // Reset state
    hw_os = 3'($urandom_range(0, 7));
    tick(3);
    check("rst_busy", 32'(hw_busy), 32'd0);
    check("rst_first", 32'(hw_first_data), 32'd0);
    check("rst_data", 32'(hw_data), 32'd0);
    check("rst_oe", 32'(hw_data_oe), 32'd0);
    check("rst_fc", 32'(frame_count), 32'd0);
    rst = 1'b0;
    tick(5);

    // Conversion timing: BUSY 3 cycles after CONVST, high for BUSY_CYCLES
    hw_range = 1'b1;
    tick(3);
    hw_convst = 1'b1;
    tick(2);
    check("conv_busy_pre", 32'(hw_busy), 32'd0);
    tick(1);
    check("conv_busy_rise", 32'(hw_busy), 32'd1);
    hw_convst = 1'b0;
    tick(BC - 1);
    check("conv_busy_last", 32'(hw_busy), 32'd1);
    tick(1);
    check("conv_busy_fall", 32'(hw_busy), 32'd0);
    check("conv_fc", 32'(frame_count), 32'd1);
    m_convert_done(1'b1);
    tick(1);
    check("conv_pulses", 32'(busy_pulses), 32'd1);
    check("conv_len", 32'(last_len), BC);

    // Frame read, 8 channels then wrap
    hw_cs = 1'b0;
    tick(3);
    for (int i = 0; i < 9; i++) do_read(5, 5, "frame", 1'b1);

    // Retrigger and reads during conversion
    p0 = busy_pulses;
    hw_convst = 1'b1;
    tick(3);
    check("retrig_busy_rise", 32'(hw_busy), 32'd1);
    tick(1);
    hw_convst = 1'b0;
    for (int i = 0; i < 3; i++) do_read(5, 5, "conv_read", 1'b1);
    tick(66);
    hw_convst = 1'b1;
    tick(4);
    hw_convst = 1'b0;
    wait_busy_low(BC + 20, "retrig");
    check("retrig_pulses", 32'(busy_pulses), 32'(p0 + 1));
    check("retrig_len", 32'(last_len), BC);
    m_convert_done(1'b1);
    check("retrig_fc", 32'(frame_count), 32'd2);
    do_read(5, 5, "post_conv", 1'b1);

    // hw_reset mid-conversion
    r = 1'($urandom_range(0, 1));
    hw_range = r;
    tick(3);
    start_conv("hwrst");
    tick(50);
    hw_reset = 1'b1;
    tick(4);
    check("hwrst_busy", 32'(hw_busy), 32'd0);
    check("hwrst_fc", 32'(frame_count), 32'd0);
    check("hwrst_oe", 32'(hw_data_oe), 32'd0);
    m_hw_reset();
    hw_reset = 1'b0;
    tick(6);
    do_read(5, 5, "hwrst_cleared", 1'b1);
    start_conv("hwrst_next");
    wait_busy_low(BC + 20, "hwrst_next");
    m_convert_done(r);
    check("hwrst_next_fc", 32'(frame_count), 32'd1);
    do_read(5, 5, "hwrst_next", 1'b1);

    // Randomized frames: random range, read count and RD# timing
    for (int f = 0; f < 4; f++) begin
      r = 1'($urandom_range(0, 1));
      hw_range = r;
      tick(3);
      start_conv("rand");
      wait_busy_low(BC + 20, "rand");
      m_convert_done(r);
      check("rand_fc", 32'(frame_count), 32'(m_fc));
      n = $urandom_range(1, 11);
      for (int unsigned k = 0; k < n; k++)
        do_read($urandom_range(4, 7), $urandom_range(4, 7), "rand", 1'b1);
    end

    // Standby from IDLE: CONVST ignored, reads still allowed
    hw_stby_n = 1'b0;
    tick(4);
    p0 = busy_pulses;
    hw_convst = 1'b1;
    tick(6);
    check("stby_busy", 32'(hw_busy), 32'd0);
    hw_convst = 1'b0;
    tick(4);
    check("stby_pulses", 32'(busy_pulses), 32'(p0));
    do_read(5, 5, "stby_read", 1'b1);
    hw_stby_n = 1'b1;
    tick(4);

    // Standby requested mid-conversion: conversion completes first
    r = 1'($urandom_range(0, 1));
    hw_range = r;
    tick(3);
    start_conv("stby_conv");
    tick(20);
    hw_stby_n = 1'b0;
    wait_busy_low(BC + 20, "stby_conv");
    m_convert_done(r);
    check("stby_conv_len", 32'(last_len), BC);
    check("stby_conv_fc", 32'(frame_count), 32'(m_fc));
    p0 = busy_pulses;
    hw_convst = 1'b1;
    tick(6);
    check("stby_conv_nobusy", 32'(hw_busy), 32'd0);
    hw_convst = 1'b0;
    tick(2);
    check("stby_conv_pulses", 32'(busy_pulses), 32'(p0));
    hw_stby_n = 1'b1;
    tick(4);

    // CS# rising during a read blanks the bus, pointer kept
    hw_rd = 1'b0;
    tick(5);
    check("cs_read_oe", 32'(hw_data_oe), 32'd1);
    check("cs_read_data", 32'(hw_data), 32'(exp_sample(m_ptr)));
    hw_cs = 1'b1;
    tick(4);
    check("cs_high_oe", 32'(hw_data_oe), 32'd0);
    check("cs_high_data", 32'(hw_data), 32'd0);
    check("cs_high_first", 32'(hw_first_data), 32'd0);
    hw_rd = 1'b1;
    tick(5);
    hw_cs = 1'b0;
    tick(3);
    do_read(5, 5, "cs_after", 1'b1);

    // Serial/byte mode blocks reads
    hw_mode_select = 1'b1;
    tick(3);
    do_read(5, 5, "mode", 1'b0);
    do_read(5, 5, "mode", 1'b0);
    hw_mode_select = 1'b0;
    tick(3);
    do_read(5, 5, "mode_after", 1'b1);

    // rst mid-conversion clears everything at the edge
    start_conv("rst_mid");
    tick(10);
    rst = 1'b1;
    tick(1);
    check("rst_mid_busy", 32'(hw_busy), 32'd0);
    check("rst_mid_fc", 32'(frame_count), 32'd0);
    check("rst_mid_oe", 32'(hw_data_oe), 32'd0);
    check("rst_mid_data", 32'(hw_data), 32'd0);
    rst = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
